// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner_if
// Description : Key-event bundle from the keypad scanner to the calculator
//               datapath.
//                 key_code  - hex code of the last accepted key
//                 key_valid - one-cycle strobe, key_code valid same cycle
//                 key_held  - high while a single key is debounced as held
//               master: the scanner (drives all three)
//               slave : the consumer (reads all three)
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    input key_code,
    input key_valid,
    input key_held
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad front end. Drives one column low at a time,
//               samples the (synchronised) rows, classifies each full scan as
//               no key / one key / ghost, debounces over whole scans and emits
//               a one-cycle strobe with a hex key code for every new press.
// Ports       : clock_100Mhz - system clock, rising edge
//               reset_n      - asynchronous active-low reset (deassertion is
//                              synchronised internally)
//               row[3:0]     - keypad rows, active low, asynchronous
//               col[3:0]     - keypad columns, exactly one bit low
//               key_if       - keypad_scanner_if.master (key_code, key_valid,
//                              key_held)
// Parameters  : SCAN_DIV       - clock cycles per column
//               DEBOUNCE_SCANS - agreeing scans needed to accept (1..15)
// Macros      : KEYPAD_REPEAT_EN - when defined, auto-repeat strobes while a
//               key stays held (first after 500 scans, then every 100)
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  wire               clock_100Mhz,
  input  wire               reset_n,
  input  wire        [3:0]  row,
  output logic       [3:0]  col,
  keypad_scanner_if.master  key_if
);

  localparam int               c_DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       c_DEB      = 4'(DEBOUNCE_SCANS);
  // Scan result encoding: {is_key, code}. NONE is distinct from KEY(0).
  localparam logic [4:0]       c_NONE     = 5'b0_0000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge so the first
  // column period is a full SCAN_DIV cycles.
  // --------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // --------------------------------------------------------------------------
  // Row synchroniser (rows idle high, so reset to "nothing pressed")
  // --------------------------------------------------------------------------
  logic [3:0] r_row_meta;
  logic [3:0] r_row_sync;

  always_ff @(posedge clock_100Mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= row;
      r_row_sync <= r_row_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Column sequencer and scan snapshot
  // --------------------------------------------------------------------------
  logic [c_DIV_W-1:0] r_div_cnt;
  logic [1:0]         r_col_idx;
  logic [3:0]         r_col;
  // Columns 0..2 only: column 3 is classified straight from the row
  // synchroniser on the completing edge, so storing it would be dead state.
  logic [11:0]        r_snapshot;
  logic               w_col_tc;
  logic               w_scan_done;
  logic [15:0]        w_scan_bits;

  assign w_col_tc    = (r_div_cnt == c_DIV_LAST);
  assign w_scan_done = w_col_tc && (r_col_idx == 2'd3);
  assign w_scan_bits = {~r_row_sync, r_snapshot};

  always_ff @(posedge clock_100Mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_div_cnt  <= '0;
      r_col_idx  <= 2'd0;
      r_col      <= 4'b1110;
      r_snapshot <= 12'h000;
    end else if (w_col_tc) begin
      r_div_cnt <= '0;
      r_col_idx <= r_col_idx + 2'd1;
      r_col     <= {r_col[2:0], r_col[3]};
      case (r_col_idx)
        2'd0:    r_snapshot[3:0]  <= ~r_row_sync;
        2'd1:    r_snapshot[7:4]  <= ~r_row_sync;
        2'd2:    r_snapshot[11:8] <= ~r_row_sync;
        default: ;
      endcase
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign col = r_col;

  // --------------------------------------------------------------------------
  // Scan classification: exactly one pressed bit is a key, anything else
  // (nothing, or a possible ghost pattern) is NONE.
  // --------------------------------------------------------------------------
  function automatic logic [3:0] f_key_code(input logic [3:0] idx);
    logic [3:0] code;
    code = 4'h0;
    case (idx)
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h4;
      4'd2:  code = 4'h7;
      4'd3:  code = 4'h0;
      4'd4:  code = 4'h2;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h8;
      4'd7:  code = 4'hF;
      4'd8:  code = 4'h3;
      4'd9:  code = 4'h6;
      4'd10: code = 4'h9;
      4'd11: code = 4'hE;
      4'd12: code = 4'hA;
      4'd13: code = 4'hB;
      4'd14: code = 4'hC;
      4'd15: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [4:0] w_hit_cnt;
  logic [3:0] w_hit_idx;
  logic [4:0] w_res;

  always_comb begin
    w_hit_cnt = 5'd0;
    w_hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_scan_bits[i]) begin
        w_hit_cnt = w_hit_cnt + 5'd1;
        w_hit_idx = 4'(i);
      end
    end
  end

  assign w_res = (w_hit_cnt == 5'd1) ? {1'b1, f_key_code(w_hit_idx)} : c_NONE;

  // --------------------------------------------------------------------------
  // Debounce over whole scans
  // --------------------------------------------------------------------------
  logic [4:0] r_prev_res;
  logic [3:0] r_agree_cnt;
  logic [4:0] r_stable;
  logic [3:0] w_agree_next;

  always_comb begin
    w_agree_next = 4'd1;
    if (w_res == r_prev_res) begin
      w_agree_next = (r_agree_cnt >= c_DEB) ? c_DEB : r_agree_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock_100Mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_prev_res  <= c_NONE;
      r_agree_cnt <= 4'd0;
      r_stable    <= c_NONE;
    end else if (w_scan_done) begin
      r_prev_res  <= w_res;
      r_agree_cnt <= w_agree_next;
      if ((w_agree_next == c_DEB) && (w_res != r_stable)) begin
        r_stable <= w_res;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Debounced key state machine. It reacts to r_stable one cycle after the
  // completing scan, which places the strobe and key_held edges there.
  // --------------------------------------------------------------------------
  state_t     r_state;
  logic [3:0] r_key_code;
  logic       r_key_valid;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [8:0] c_REP_FIRST = 9'd500;
  localparam logic [8:0] c_REP_NEXT  = 9'd100;
  logic [8:0] r_rep_cnt;
  logic       r_rep_first;
  logic [8:0] w_rep_limit;

  assign w_rep_limit = r_rep_first ? c_REP_FIRST : c_REP_NEXT;
`endif

  always_ff @(posedge clock_100Mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= 9'd0;
      r_rep_first <= 1'b0;
`endif
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_stable[4]) begin
            r_state     <= ST_HELD;
            r_key_code  <= r_stable[3:0];
            r_key_valid <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= 9'd0;
            r_rep_first <= 1'b1;
`endif
          end
        end
        ST_HELD: begin
          if (!r_stable[4]) begin
            // Release: no strobe, last code is kept for the display.
            r_state <= ST_IDLE;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt <= 9'd0;
`endif
          end else if (r_stable[3:0] != r_key_code) begin
            // Roll-over straight to another key.
            r_key_code  <= r_stable[3:0];
            r_key_valid <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= 9'd0;
            r_rep_first <= 1'b1;
`endif
          end
`ifdef KEYPAD_REPEAT_EN
          // Count only scans that still show the held key, so the scan that
          // is about to release it cannot fire a late repeat.
          else if (w_scan_done && (w_res == r_stable)) begin
            if (r_rep_cnt + 9'd1 == w_rep_limit) begin
              r_key_valid <= 1'b1;
              r_rep_cnt   <= 9'd0;
              r_rep_first <= 1'b0;
            end else begin
              r_rep_cnt <= r_rep_cnt + 9'd1;
            end
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign key_if.key_code  = r_key_code;
  assign key_if.key_valid = r_key_valid;
  assign key_if.key_held  = (r_state == ST_HELD);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner. A physical keypad
//               model turns a pressed-key matrix into row levels from the
//               DUT's column drive; a scan-level reference model predicts
//               col / key_valid / key_held / key_code every cycle.
//               Honours KEYPAD_REPEAT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int SCAN_LEN = 4 * SCAN_DIV;

  logic        clock_100Mhz = 1'b0;
  logic        reset_n      = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] mat = 16'h0000;   // bit c*4+r = key at column c, row r pressed

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset_n      (reset_n),
    .row          (row),
    .col          (col),
    .key_if       (kif)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  // Physical keypad: a row reads low when a pressed key connects it to a
  // column currently driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (mat[c*4+r] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  int n_cmp   = 0;
  int n_bad   = 0;
  int strobes = 0;
  bit run     = 1'b0;

  logic [3:0] exp_col   = 4'b1110;
  logic [3:0] exp_code  = 4'h0;
  logic       exp_valid = 1'b0;
  logic       exp_held  = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the reference model.
  always @(negedge clock_100Mhz) begin
    if (run) begin
      chk("col", col, exp_col);
      chk("key_valid", {3'b000, kif.key_valid}, {3'b000, exp_valid});
      chk("key_held", {3'b000, kif.key_held}, {3'b000, exp_held});
      chk("key_code", kif.key_code, exp_code);
      if (kif.key_valid) strobes++;
    end
  end

  // ---------------------------------------------------------------- model
  logic [3:0] code_tab [16];
  int  n;          // rising edges since internal reset release
  int  m_prev, m_agree, m_stable, m_code;   // -1 = NONE
  bit  m_held, m_pend;
  int  rep;
  bit  rep_first;

  function automatic int classify(input logic [15:0] m);
    if ($countones(m) != 1) return -1;
    for (int i = 0; i < 16; i++) if (m[i]) return int'(code_tab[i]);
    return -1;
  endfunction

  task automatic model_reset();
    n = 0; m_prev = -1; m_agree = 0; m_stable = -1; m_code = 0;
    m_held = 1'b0; m_pend = 1'b0; rep = 0; rep_first = 1'b0;
    exp_col = 4'b1110; exp_valid = 1'b0; exp_held = 1'b0; exp_code = 4'h0;
  endtask

  task automatic step();
    logic [3:0] one_hot;
    int res;
    @(posedge clock_100Mhz);
    #1;
    n++;
    exp_valid = 1'b0;
    one_hot   = 4'b0001 << ((n / SCAN_DIV) % 4);
    exp_col   = ~one_hot;
    if ((n % SCAN_LEN == 1) && m_pend) begin
      m_pend = 1'b0;
      if (m_stable >= 0) begin
        if (!m_held || m_stable != m_code) begin
          exp_valid = 1'b1;
          m_code    = m_stable;
          rep       = 0;
          rep_first = 1'b1;
        end
        m_held = 1'b1;
      end else begin
        m_held = 1'b0;
        rep    = 0;
      end
    end
    if (n % SCAN_LEN == 0) begin
      res = classify(mat);
`ifdef KEYPAD_REPEAT_EN
      if (m_held && res == m_code) begin
        rep++;
        if (rep == (rep_first ? 500 : 100)) begin
          exp_valid = 1'b1;
          rep       = 0;
          rep_first = 1'b0;
        end
      end
`endif
      m_agree = (res == m_prev) ? ((m_agree + 1 > DEB) ? DEB : m_agree + 1) : 1;
      m_prev  = res;
      if (m_agree == DEB && res != m_stable) begin
        m_stable = res;
        m_pend   = 1'b1;
      end
    end
    exp_held = m_held;
    exp_code = 4'(m_code);
  endtask

  // Hold a key matrix for a number of whole scans (call on a scan boundary).
  task automatic scans(input logic [15:0] m, input int count);
    mat = m;
    repeat (count * SCAN_LEN) step();
  endtask

  task automatic release_reset();
    @(negedge clock_100Mhz);
    reset_n = 1'b1;
    @(posedge clock_100Mhz);
    @(posedge clock_100Mhz);
    #1;
    model_reset();
    run = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_col"}, col, 4'b1110);
    chk({tag, "_valid"}, {3'b000, kif.key_valid}, 4'h0);
    chk({tag, "_held"}, {3'b000, kif.key_held}, 4'h0);
    chk({tag, "_code"}, kif.key_code, 4'h0);
  endtask

  localparam logic [15:0] K1 = 16'h0001;  // c0 r0
  localparam logic [15:0] K2 = 16'h0010;  // c1 r0
  localparam logic [15:0] K0 = 16'h0008;  // c0 r3
  localparam logic [15:0] K5 = 16'h0020;  // c1 r1
  localparam logic [15:0] K9 = 16'h0400;  // c2 r2
  localparam logic [15:0] KA = 16'h1000;  // c3 r0
  localparam logic [15:0] KD = 16'h8000;  // c3 r3

  initial begin
    int s0;
    int exp_rep;
    code_tab = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                 4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};
    model_reset();

    // Reset and idle
    repeat (3) @(posedge clock_100Mhz);
    #1;
    chk_reset_outputs("reset");
    release_reset();
    s0 = strobes;
    scans(16'h0000, 3);
    chk_int("idle_strobes", strobes - s0, 0);

    // Clean press of key 5, then release
    s0 = strobes;
    scans(K5, 4);
    chk("press5_code", kif.key_code, 4'h5);
    chk("press5_held", {3'b000, kif.key_held}, 4'h1);
    chk_int("press5_strobes", strobes - s0, 1);
    scans(16'h0000, 3);
    chk("rel5_held", {3'b000, kif.key_held}, 4'h0);
    chk("rel5_code", kif.key_code, 4'h5);
    chk_int("rel5_strobes", strobes - s0, 1);

    // Bounce on key 9
    s0 = strobes;
    for (int i = 0; i < 3; i++) begin
      scans(K9, 1);
      scans(16'h0000, 1);
    end
    scans(16'h0000, 1);
    chk_int("bounce_strobes", strobes - s0, 0);
    chk("bounce_held", {3'b000, kif.key_held}, 4'h0);

    // Ghost, single key, roll-over
    s0 = strobes;
    scans(K1 | K2, 3);
    chk_int("ghost_strobes", strobes - s0, 0);
    scans(K1, 3);
    chk("key1_code", kif.key_code, 4'h1);
    chk_int("key1_strobes", strobes - s0, 1);
    scans(KD, 3);
    chk("rollD_code", kif.key_code, 4'hD);
    chk("rollD_held", {3'b000, kif.key_held}, 4'h1);
    chk_int("rollD_strobes", strobes - s0, 2);

    // Reset in the middle of debouncing key 0
    scans(K0, 1);
    repeat (SCAN_LEN / 2) step();
    reset_n = 1'b0;
    run     = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (3) @(posedge clock_100Mhz);
    release_reset();
    s0 = strobes;
    scans(16'h0000, 3);
    chk_int("midrst_strobes", strobes - s0, 0);
    chk("midrst_code", kif.key_code, 4'h0);
    chk("midrst_held", {3'b000, kif.key_held}, 4'h0);

    // Long hold of key A
    s0 = strobes;
    scans(KA, 700);
    scans(16'h0000, 3);
`ifdef KEYPAD_REPEAT_EN
    exp_rep = 3;
`else
    exp_rep = 1;
`endif
    chk_int("holdA_strobes", strobes - s0, exp_rep);
    chk("holdA_code", kif.key_code, 4'hA);
    chk("holdA_held", {3'b000, kif.key_held}, 4'h0);

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side front end for the calculator: scans a 4x4 matrix keypad (Pmod KYPD on the Basys 3 Pmod header) by driving one column low at a time and sampling the rows. It debounces the result over whole scans and rejects multi-key ghosts. It delivers each new keypress as a 4-bit hex key code with a one-cycle valid strobe. Its outputs replace raw switch/button inputs feeding the calculator datapath, which in turn drives the 7-segment display.

## Interface
- SCAN_DIV, default 25000: clock cycles each column stays driven. One scan is 4*SCAN_DIV cycles, 1 ms at 100 MHz.
- DEBOUNCE_SCANS, default 4: number of consecutive identical scan results required before the result is accepted; legal range 1..15.

- clock_100Mhz  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- row  input  4  keypad rows, active-low (pulled up externally), asynchronous to clock.
- col  output  4  keypad columns; exactly one bit low at any time.
- key_code  output  4  hex code of the last accepted key; holds until the next accepted key.
- key_valid  output  1  one-cycle strobe; key_code is valid in the same cycle.
- key_held  output  1  high while the debounced state is a single pressed key.

## Operation
- row passes through a 2-FF synchronizer before any use.
- Column sequencer:
  - col_idx counts 0..3; col = ~(4'b0001 << col_idx).
  - A cycle counter runs 0..SCAN_DIV-1 per column. On its terminal count, the synchronized row is sampled into snapshot bits [col_idx*4 +: 4] (inverted, 1 = pressed), and col_idx advances, wrapping 3 -> 0.
  - A scan completes on the col_idx=3 terminal count.
- Scan classification at scan completion:
  - Zero bits set: NONE.
  - Exactly one bit set: KEY(code).
  - Two or more bits set: NONE (ghost rejection).
- Code map, indexed by column c and row r = 0..3:
  - c0: 1,4,7,0
  - c1: 2,5,8,F
  - c2: 3,6,9,E
  - c3: A,B,C,D
- Debounce:
  - Each classified result is compared with the previous one. If equal, agree_cnt increments, saturating at DEBOUNCE_SCANS; otherwise agree_cnt is set to 1.
  - When agree_cnt reaches DEBOUNCE_SCANS and the result differs from the current stable state, stable takes the result.
- Debounced state machine, states IDLE and HELD:
  - IDLE -> HELD when stable becomes KEY(k): key_code <= k, pulse key_valid.
  - HELD -> HELD when stable becomes KEY(j) with j != k (direct roll-over): key_code <= j, pulse key_valid.
  - HELD -> IDLE when stable becomes NONE: no pulse; key_code is retained.
  - key_held = (state == HELD).
- No repeat strobes while held, unless the repeat feature is compiled in (see Configuration).

## Timing
- Reset values:
  - col = 4'b1110
  - key_code = 4'h0
  - key_valid = 0
  - key_held = 0
  - all counters, snapshot and agree_cnt = 0
  - previous result and stable = NONE
  - state = IDLE
- Deassertion of reset_n must be synchronized internally so the first column period is exactly SCAN_DIV cycles.
- Each column is low for exactly SCAN_DIV cycles, with no gap between columns.
- Row sampling reflects the pin state 2 cycles before the terminal count.
- key_valid rises 1 cycle after the scan completion that satisfies debounce, and lasts exactly 1 cycle.
- key_held changes in the same cycle that key_valid rises (press), or 1 cycle after the satisfying scan (release).
- Minimum press-to-strobe latency is DEBOUNCE_SCANS scans plus up to one partial scan.
- Reset asserted mid-scan or mid-debounce: all state clears immediately and no pending strobe is emitted.

## Configuration
- KEYPAD_REPEAT_EN defined: auto-repeat is enabled.
  - While in HELD with an unchanged key, key_valid re-pulses with the same key_code 500 scans after the accepting strobe, then every 100 scans.
  - The repeat counter clears on any state or key change and on reset.
- KEYPAD_REPEAT_EN undefined: no repeat logic is synthesized; exactly one strobe per accepted press.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2, so one scan is 16 cycles.
- Reset and idle: hold reset_n low, release, keep row=4'hF -> col steps 1110, 1101, 1011, 0111 for 4 cycles each and repeats; key_valid stays 0, key_held stays 0, key_code stays 0.
- Clean press: drive row[1] low only while col[1] is low, for 4 scans -> one key_valid pulse with key_code=4'h5 at the end of the second agreeing scan, and key_held=1. Then release -> key_held=0 after 2 empty scans, with no pulse and key_code still 5.
- Bounce: press key 9 (c2, r2) on alternate scans for 6 scans -> no key_valid; key_held stays 0.
- Ghost and roll-over: hold keys 1 and 2 together for 3 scans -> no strobe. Release 2 -> a single strobe with code 1. Then move directly to key D -> strobe with code D, with key_held staying 1 throughout.
- Reset mid-debounce: press key 0 and assert reset_n after 1 scan, release reset, then release the key -> no strobe at any time; outputs equal the reset values.
- KEYPAD_REPEAT_EN defined: hold key A for 700 scans -> strobes at acceptance, at +500 scans and at +600 scans, all with key_code=4'hA. Without the macro -> exactly 1 strobe.
